pipe_skid: RTL and testbench

// - Flow-controlled register slice: valid/ready consumer on the in_* side, producer on the out_* side.
// - Breaks the timing path on both data/valid (forward) and ready (backward) with no bubbles.
// - Used wherever the plain data flop cannot absorb back-pressure.
// - Two storage entries: main (drives out_data) and skid (catches the beat accepted while out_ready falls).
//

---
 rtl/pipe_skid_pkg.sv | 19 +
 rtl/dff.sv | 14 +
 rtl/pipe_skid.sv | 84 ++++++++
 tb/tb_pipe_skid.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_pkg.sv
// rtl/pipe_skid_pkg.sv - state encoding and decode helpers for the pipe_skid register slice
package pipe_skid_pkg;

  // Bit 0 is out_valid, bit 1 is !in_ready, so both handshakes decode from single flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  function automatic logic st_in_ready(input state_t s);
    return ~s[1];
  endfunction

  function automatic logic st_out_valid(input state_t s);
    return s[0];
  endfunction

endpackage

// File: rtl/dff.sv
// rtl/dff.sv - plain unreset data register used for the main and skid entries
module dff #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk) begin
    q_o <= d_i;
  end

endmodule

// File: rtl/pipe_skid.sv
// rtl/pipe_skid.sv - two-entry skid register slice, valid/ready on both sides
// Optional same-cycle pass-through from EMPTY when PIPE_SKID_BYPASS_EN is defined.
module pipe_skid
  import pipe_skid_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready
);

  state_t         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Enables are folded into d: each entry recirculates unless this cycle loads it.
  dff #(.W(W)) u_main (.clk(clk), .d_i(main_d), .q_o(main_q));
  dff #(.W(W)) u_skid (.clk(clk), .d_i(skid_d), .q_o(skid_q));

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_valid) begin
`ifdef PIPE_SKID_BYPASS_EN
          if (!out_ready) begin
            state_d = ONE;
            main_d  = in_data;
          end
`else
          state_d = ONE;
          main_d  = in_data;
`endif
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          main_d = in_data;
        end else if (in_valid) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign in_ready = st_in_ready(state_q);

`ifdef PIPE_SKID_BYPASS_EN
  logic bypass;
  assign bypass    = (state_q == EMPTY) && in_valid && out_ready;
  assign out_valid = st_out_valid(state_q) | bypass;
  assign out_data  = bypass ? in_data : main_q;
`else
  assign out_valid = st_out_valid(state_q);
  assign out_data  = main_q;
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// tb/tb_pipe_skid.sv - directed and randomized bench for pipe_skid
module tb_pipe_skid;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         arst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  int n_vec = 0;
  int n_err = 0;

  pipe_skid #(.W(W)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    step(); step();
    arst_n = 1'b1;
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle got %b want 0", out_valid); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      in_valid = (k < 8);
      in_data  = k + 1;
      n_vec++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready k=%0d got %b want 1", k, in_ready); end
      n_vec++;
      if (out_valid !== (k > 0)) begin n_err++; $display("FAIL stream_out_valid k=%0d got %b want %b", k, out_valid, k > 0); end
      if (k > 0) begin
        n_vec++;
        if (out_data !== k) begin n_err++; $display("FAIL stream_data k=%0d got %h want %h", k, out_data, k); end
      end
      step();
    end
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hA; step();
    in_valid = 1'b1; in_data = 32'hB; step();
    for (int h = 0; h < 2; h++) begin
      in_valid = 1'b1; in_data = 32'h99;
      n_vec++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_in_ready h=%0d got %b want 0", h, in_ready); end
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 32'hA) begin
        n_err++; $display("FAIL bp_hold h=%0d got v=%b d=%h want v=1 d=a", h, out_valid, out_data);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_vec++;
    if (out_data !== 32'hA) begin n_err++; $display("FAIL bp_pop_a got %h want a", out_data); end
    step();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_pop_b got v=%b d=%h rdy=%b want v=1 d=b rdy=1", out_valid, out_data, in_ready);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h5; step();
    in_valid = 1'b1; in_data = 32'h6; out_ready = 1'b1;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'h5) begin
      n_err++; $display("FAIL simul_before got v=%b d=%h want v=1 d=5", out_valid, out_data);
    end
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'h6 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL simul_after got v=%b d=%h rdy=%b want v=1 d=6 rdy=1", out_valid, out_data, in_ready);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL simul_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'hC; step();
    in_valid = 1'b1; in_data = 32'hD; step();
    in_valid = 1'b0;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL midop_full got rdy=%b want 0", in_ready); end
    #2 arst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL midop_async got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    step();
    #2 arst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 32'hE; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 32'hE) begin
      n_err++; $display("FAIL midop_e got v=%b d=%h want v=1 d=e", out_valid, out_data);
    end
    step();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL midop_no_replay got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp;
    logic         stalled = 1'b0;
    logic [W-1:0] prev = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      n_vec++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        n_err++; $display("FAIL rand_flags c=%0d got v=%b rdy=%b want occupancy %0d", c, out_valid, in_ready, q.size());
      end
      if (stalled) begin
        n_vec++;
        if (out_data !== prev) begin n_err++; $display("FAIL rand_stable c=%0d got %h want %h", c, out_data, prev); end
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp = q.pop_front();
        n_vec++;
        if (out_data !== exp) begin n_err++; $display("FAIL rand_order c=%0d got %h want %h", c, out_data, exp); end
      end
      if (in_valid && in_ready) q.push_back(in_data);
      stalled = out_valid && !out_ready;
      prev    = out_data;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid && q.size() > 0) begin
        exp = q.pop_front();
        n_vec++;
        if (out_data !== exp) begin n_err++; $display("FAIL rand_drain c=%0d got %h want %h", c, out_data, exp); end
      end
      step();
    end
    n_vec++;
    if (q.size() != 0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL rand_final got left=%0d v=%b want left=0 v=0", q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_simultaneous();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
